// File: rtl/prefetch_line_buf.sv
// prefetch_line_buf: direct-mapped, multi-word-line prefetch buffer.
// Hits return data one cycle after RDReq. A miss starts an autonomous
// line fill over the bus, and snooped CPU writes keep buffered copies coherent.
//
// Fill handshake: FillReq is asserted in REQ with FillA stable and stays high
// until FillAck is sampled high on a rising edge. After that the bus delivers
// WORDS words in ascending offset order. Each word is marked by FillValid high
// on a rising edge. FillValid is ignored outside BURST.
module prefetch_line_buf #(
  parameter int AW    = 32,
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [AW-1:0] RDA,
  input  logic          RDReq,
  output logic [31:0]   RDD,
  output logic          RDValid,
  output logic          Match,
  output logic          FillReq,
  output logic [AW-1:0] FillA,
  input  logic          FillAck,
  input  logic          FillValid,
  input  logic [31:0]   FillD,
  output logic          Busy,
  input  logic [AW-1:0] WRA,
  input  logic [31:0]   WRD,
  input  logic [3:0]    WE,
  input  logic          Flush,
  output logic [1:0]    DbgState
);

  localparam int OW = $clog2(WORDS);
  localparam int OB = 2 + OW;
  localparam int IB = $clog2(LINES);
  localparam int TB = AW - OB - IB;
  localparam int MW = IB + OW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BURST = 2'd2
  } state_e;

  // Storage and control state
  state_e          state_q, state_d;
  logic [OW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   fill_a_q, fill_a_d;
  logic            poison_q, poison_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TB-1:0]   tag_q [LINES];
  logic [31:0]     mem_q [LINES*WORDS];
  logic            rd_valid_q, match_q;
  logic [31:0]     rdd_q;

  // Address fields
  logic [OW-1:0] rd_off, s_off;
  logic [IB-1:0] rd_idx, s_idx, fill_idx;
  logic [TB-1:0] rd_tag, s_tag, fill_tag;

  assign rd_off   = RDA[OB-1:2];
  assign rd_idx   = RDA[OB+IB-1:OB];
  assign rd_tag   = RDA[AW-1:OB+IB];
  assign s_off    = WRA[OB-1:2];
  assign s_idx    = WRA[OB+IB-1:OB];
  assign s_tag    = WRA[AW-1:OB+IB];
  assign fill_idx = fill_a_q[OB+IB-1:OB];
  assign fill_tag = fill_a_q[AW-1:OB+IB];

  // Byte-lane bits of the addresses and the low bits of FillA carry no information
  logic unused_addr_bits;
  assign unused_addr_bits = ^{RDA[1:0], WRA[1:0], fill_a_q[OB-1:0]};

  // Lookup, fill and snoop qualifiers
  logic          busy;
  logic          rd_hit, miss_start;
  logic          fill_we, fill_last;
  logic          snoop_any, snoop_line_hit, snoop_fill, snoop_new, snoop_we;
  logic [MW-1:0] rd_addr, fill_addr, snp_addr;
  logic [31:0]   snp_word;

  assign busy       = (state_q != S_IDLE);
  assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign miss_start = RDReq && !rd_hit && (state_q == S_IDLE) && !Flush;
  assign fill_we    = (state_q == S_BURST) && FillValid;
  assign fill_last  = fill_we && (&cnt_q);
  assign rd_addr    = {rd_idx, rd_off};
  assign fill_addr  = {fill_idx, cnt_q};
  assign snp_addr   = {s_idx, s_off};

  assign snoop_any      = |WE;
  assign snoop_line_hit = snoop_any && valid_q[s_idx] && (tag_q[s_idx] == s_tag);
  // Write to the line currently being filled
  assign snoop_fill     = snoop_any && busy && (s_idx == fill_idx) && (s_tag == fill_tag);
  // Write to the line whose fill is being launched in this very cycle
  assign snoop_new      = snoop_any && miss_start && (s_idx == rd_idx) && (s_tag == rd_tag);
  assign snoop_we       = snoop_line_hit || snoop_fill;

  // Merge snooped bytes over the word; a same-cycle fill word is the base so snoop bytes win
  always_comb begin
    snp_word = (fill_we && (fill_addr == snp_addr)) ? FillD : mem_q[snp_addr];
    for (int b = 0; b < 4; b++) begin
      if (WE[b]) snp_word[8*b +: 8] = WRD[8*b +: 8];
    end
  end

  // Fill FSM next state, fill address, counter, poison and valid bits
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fill_a_d = fill_a_q;
    poison_d = poison_q || (busy && (Flush || snoop_fill));
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (miss_start) begin
          state_d          = S_REQ;
          fill_a_d         = {rd_tag, rd_idx, {OB{1'b0}}};
          poison_d         = snoop_new;
          valid_d[rd_idx]  = 1'b0;
        end
      end
      S_REQ: begin
        if (FillAck) begin
          state_d = S_BURST;
          cnt_d   = '0;
        end
      end
      S_BURST: begin
        if (fill_we) cnt_d = cnt_q + 1'b1;
        if (fill_last) begin
          state_d = S_IDLE;
          if (!poison_d) valid_d[fill_idx] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (Flush) valid_d = '0;
  end

  // Control registers with asynchronous reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fill_a_q   <= '0;
      poison_q   <= 1'b0;
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      match_q    <= 1'b0;
      rdd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_a_q   <= fill_a_d;
      poison_q   <= poison_d;
      valid_q    <= valid_d;
      rd_valid_q <= RDReq;
      match_q    <= RDReq && rd_hit;
      if (RDReq && rd_hit) rdd_q <= mem_q[rd_addr];
    end
  end

  // Tag RAM: loaded when a fill is launched
  always_ff @(posedge CLK) begin
    if (miss_start) tag_q[rd_idx] <= rd_tag;
  end

  // Data RAM: fill word first, snoop merge second so it takes priority on the same word
  always_ff @(posedge CLK) begin
    if (fill_we)  mem_q[fill_addr] <= FillD;
    if (snoop_we) mem_q[snp_addr]  <= snp_word;
  end

  assign RDD      = rdd_q;
  assign RDValid  = rd_valid_q;
  assign Match    = match_q;
  assign FillReq  = (state_q == S_REQ);
  assign FillA    = fill_a_q;
  assign Busy     = busy;
  assign DbgState = state_q;

endmodule

// File: tb/tb_prefetch_line_buf.sv
// Directed bench for prefetch_line_buf with hand-computed expectations.
module tb_prefetch_line_buf;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] RDA;
  logic        RDReq;
  logic [31:0] RDD;
  logic        RDValid;
  logic        Match;
  logic        FillReq;
  logic [31:0] FillA;
  logic        FillAck;
  logic        FillValid;
  logic [31:0] FillD;
  logic        Busy;
  logic [31:0] WRA;
  logic [31:0] WRD;
  logic [3:0]  WE;
  logic        Flush;
  logic [1:0]  DbgState;

  int n_assert = 0;
  int n_fail   = 0;

  prefetch_line_buf #(.AW(32), .LINES(64), .WORDS(4)) dut (
    .CLK(CLK), .nRST(nRST), .RDA(RDA), .RDReq(RDReq), .RDD(RDD),
    .RDValid(RDValid), .Match(Match), .FillReq(FillReq), .FillA(FillA),
    .FillAck(FillAck), .FillValid(FillValid), .FillD(FillD), .Busy(Busy),
    .WRA(WRA), .WRD(WRD), .WE(WE), .Flush(Flush), .DbgState(DbgState)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] addr);
    RDA   = addr;
    RDReq = 1'b1;
    step();
    RDReq = 1'b0;
  endtask

  task automatic fill_line(input logic [31:0] addr, input logic [31:0] base);
    rd(addr);
    chk("fl_miss", {31'd0, Match}, 32'd0);
    chk("fl_req", {31'd0, FillReq}, 32'd1);
    chk("fl_addr", FillA, addr & 32'hFFFF_FFF0);
    FillAck = 1'b1;
    step();
    FillAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      FillValid = 1'b1;
      FillD     = base + i;
      step();
    end
    FillValid = 1'b0;
    chk("fl_done", {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    nRST = 1'b0; RDA = '0; RDReq = 1'b0; FillAck = 1'b0; FillValid = 1'b0;
    FillD = '0; WRA = '0; WRD = '0; WE = '0; Flush = 1'b0;
    step();
    step();
    chk("rst_rdvalid", {31'd0, RDValid}, 32'd0);
    chk("rst_match", {31'd0, Match}, 32'd0);
    chk("rst_fillreq", {31'd0, FillReq}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_filla", FillA, 32'd0);
    chk("rst_rdd", RDD, 32'd0);
    chk("rst_state", {30'd0, DbgState}, 32'd0);
    nRST = 1'b1;
    step();

    // First miss and line fill
    rd(32'h0000_1000);
    chk("m1_rdvalid", {31'd0, RDValid}, 32'd1);
    chk("m1_match", {31'd0, Match}, 32'd0);
    chk("m1_fillreq", {31'd0, FillReq}, 32'd1);
    chk("m1_filla", FillA, 32'h0000_1000);
    chk("m1_busy", {31'd0, Busy}, 32'd1);
    FillAck = 1'b1;
    step();
    FillAck = 1'b0;
    chk("m1_req_drop", {31'd0, FillReq}, 32'd0);
    chk("m1_idle_rdvalid", {31'd0, RDValid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      FillValid = 1'b1;
      FillD     = 32'hA0 + i;
      step();
    end
    FillValid = 1'b0;
    chk("m1_done", {31'd0, Busy}, 32'd0);
    rd(32'h0000_1008);
    chk("h1_match", {31'd0, Match}, 32'd1);
    chk("h1_rdd", RDD, 32'h0000_00A2);

    // Snoop write-through, then a snoop to a different tag
    WRA = 32'h0000_1004; WRD = 32'h1234_5678; WE = 4'b0011;
    step();
    WE = 4'b0000;
    rd(32'h0000_1004);
    chk("sn_match", {31'd0, Match}, 32'd1);
    chk("sn_rdd", RDD, 32'h0000_5678);
    WRA = 32'h0000_2004; WRD = 32'hFFFF_FFFF; WE = 4'b1111;
    step();
    WE = 4'b0000;
    rd(32'h0000_1004);
    chk("sn_other_match", {31'd0, Match}, 32'd1);
    chk("sn_other_rdd", RDD, 32'h0000_5678);

    // Poison by snoop concurrent with the last fill word of the same word
    rd(32'h0000_3000);
    chk("p_match", {31'd0, Match}, 32'd0);
    chk("p_filla", FillA, 32'h0000_3000);
    FillAck = 1'b1;
    step();
    FillAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      FillValid = 1'b1;
      FillD     = 32'hB0 + i;
      step();
    end
    FillD = 32'hB3; WRA = 32'h0000_300C; WRD = 32'hDEAD_BEEF; WE = 4'b1111;
    step();
    FillValid = 1'b0; WE = 4'b0000;
    chk("p_done", {31'd0, Busy}, 32'd0);
    rd(32'h0000_3000);
    chk("p_retry_match", {31'd0, Match}, 32'd0);
    chk("p_retry_req", {31'd0, FillReq}, 32'd1);
    chk("p_retry_filla", FillA, 32'h0000_3000);
    FillAck = 1'b1;
    step();
    FillAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      FillValid = 1'b1;
      FillD     = 32'hC0 + i;
      step();
    end
    FillValid = 1'b0;
    rd(32'h0000_300C);
    chk("p_refill_match", {31'd0, Match}, 32'd1);
    chk("p_refill_rdd", RDD, 32'h0000_00C3);

    // Restore 0x1000, then hits and blocked misses during a fill of 0x4010
    fill_line(32'h0000_1000, 32'hA0);
    rd(32'h0000_4010);
    chk("b_req", {31'd0, FillReq}, 32'd1);
    chk("b_filla", FillA, 32'h0000_4010);
    FillAck = 1'b1;
    step();
    FillAck = 1'b0;
    FillValid = 1'b1; FillD = 32'hD0;
    step();
    FillD = 32'hD1; RDA = 32'h0000_1004; RDReq = 1'b1;
    step();
    RDReq = 1'b0;
    chk("b_hit_match", {31'd0, Match}, 32'd1);
    chk("b_hit_rdd", RDD, 32'h0000_00A1);
    chk("b_hit_busy", {31'd0, Busy}, 32'd1);
    FillD = 32'hD2; RDA = 32'h0000_5000; RDReq = 1'b1;
    step();
    RDReq = 1'b0;
    chk("b_miss_rdvalid", {31'd0, RDValid}, 32'd1);
    chk("b_miss_match", {31'd0, Match}, 32'd0);
    chk("b_miss_rdd_hold", RDD, 32'h0000_00A1);
    chk("b_miss_filla", FillA, 32'h0000_4010);
    chk("b_miss_noreq", {31'd0, FillReq}, 32'd0);
    FillD = 32'hD3;
    step();
    FillValid = 1'b0;
    chk("b_done", {31'd0, Busy}, 32'd0);
    step();
    chk("b_no_queue", {31'd0, FillReq}, 32'd0);
    rd(32'h0000_4018);
    chk("b_line_match", {31'd0, Match}, 32'd1);
    chk("b_line_rdd", RDD, 32'h0000_00D2);

    // Flush with two valid lines
    fill_line(32'h0000_1010, 32'hE0);
    rd(32'h0000_1010);
    chk("f_pre_match", {31'd0, Match}, 32'd1);
    chk("f_pre_rdd", RDD, 32'h0000_00E0);
    Flush = 1'b1;
    rd(32'h0000_1000);
    Flush = 1'b0;
    chk("f_conc_match", {31'd0, Match}, 32'd1);
    chk("f_conc_rdd", RDD, 32'h0000_00A0);
    rd(32'h0000_1014);
    chk("f_l1_match", {31'd0, Match}, 32'd0);
    chk("f_l1_req", {31'd0, FillReq}, 32'd1);
    rd(32'h0000_1000);
    chk("f_l0_match", {31'd0, Match}, 32'd0);
    chk("f_l0_filla", FillA, 32'h0000_1010);

    // Flush during the burst leaves the line invalid
    FillAck = 1'b1;
    step();
    FillAck = 1'b0;
    FillValid = 1'b1; FillD = 32'h70;
    step();
    FillD = 32'h71; Flush = 1'b1;
    step();
    Flush = 1'b0; FillD = 32'h72;
    step();
    FillD = 32'h73;
    step();
    FillValid = 1'b0;
    chk("fb_done", {31'd0, Busy}, 32'd0);
    rd(32'h0000_1010);
    chk("fb_match", {31'd0, Match}, 32'd0);
    chk("fb_req", {31'd0, FillReq}, 32'd1);
    chk("fb_filla", FillA, 32'h0000_1010);

    // Reset in the middle of the burst
    FillAck = 1'b1;
    step();
    FillAck = 1'b0;
    FillValid = 1'b1; FillD = 32'h80;
    step();
    FillD = 32'h81; RDA = 32'h0000_1004; RDReq = 1'b1;
    step();
    FillValid = 1'b0; RDReq = 1'b0;
    chk("r_pre_rdvalid", {31'd0, RDValid}, 32'd1);
    chk("r_pre_busy", {31'd0, Busy}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("r_fillreq", {31'd0, FillReq}, 32'd0);
    chk("r_busy", {31'd0, Busy}, 32'd0);
    chk("r_rdvalid", {31'd0, RDValid}, 32'd0);
    step();
    nRST = 1'b1;
    rd(32'h0000_1010);
    chk("r_post_rdvalid", {31'd0, RDValid}, 32'd1);
    chk("r_post_match", {31'd0, Match}, 32'd0);
    chk("r_post_req", {31'd0, FillReq}, 32'd1);
    chk("r_post_filla", FillA, 32'h0000_1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_line_buf.md
Name: prefetch_line_buf

Overview:
- Parametrised successor to the single-port-pair prefetch RAM: a direct-mapped, multi-word-line prefetch buffer with tags, per-line valid bits, an autonomous miss-fill state machine and write-snoop coherence.
- Sits between the CPU instruction/data read path and the board memory bus.
- Serves hits with fixed 1-cycle latency.
- On a miss, fetches a whole line over a req/ack + valid burst interface.
- Observed CPU writes are applied to buffered copies, so stale data is never returned.

Parameters:
- AW, 32, byte address width.
- LINES, 64, number of lines; power of two, ≥2.
- WORDS, 4, 32-bit words per line; power of two, ≥2.
- Derived: OB=2+log2(WORDS) offset bits, IB=log2(LINES) index bits, TB=AW-OB-IB tag bits.

Ports:
- CLK  in  1  single clock, all state rising-edge.
- nRST  in  1  asynchronous active-low reset.
- RDA  in  AW  read byte address; bits [1:0] ignored.
- RDReq  in  1  read request strobe.
- RDD  out  32  read data, valid when RDValid & Match.
- RDValid  out  1  response to previous-cycle RDReq.
- Match  out  1  with RDValid: 1 = hit, 0 = miss.
- FillReq  out  1  line fill request, held until FillAck.
- FillA  out  AW  line-aligned fill address (low OB bits zero).
- FillAck  in  1  bus accepted request.
- FillValid  in  1  one fill word present.
- FillD  in  32  fill word.
- Busy  out  1  fill FSM not IDLE.
- WRA  in  AW  snooped write byte address.
- WRD  in  32  snooped write data.
- WE  in  4  snooped byte enables; WE[3] = WRD[31:24].
- Flush  in  1  invalidate all lines.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All valid bits 0; FSM IDLE.
  - RDValid=0, Match=0, FillReq=0, Busy=0, FillA=0, RDD=0.
  - Data/tag RAM contents undefined.
- Address split:
  - offset = A[OB-1:2]; index = A[OB+IB-1:OB]; tag = A[AW-1:OB+IB].
- Read, 1-cycle latency:
  - RDReq in cycle N → cycle N+1: RDValid=1.
  - Match = valid[index] & tag==tagram[index], evaluated against state at end of cycle N.
  - RDD = word; RDD holds its last value when there is no hit.
  - Without RDReq, RDValid=0 next cycle.
- Miss handling, FSM states IDLE → REQ → BURST → IDLE:
  - IDLE: a miss response with FSM IDLE and no Flush in the same cycle enters REQ next cycle.
    - Latches FillA = {tag,index,0}.
    - Clears valid[index] and loads the tag.
    - Clears the poison flag.
  - REQ: FillReq=1 until FillAck sampled high; then BURST with word counter=0.
  - BURST: each FillValid writes FillD to word[counter] and increments counter, ascending from offset 0. When word WORDS-1 is written: valid[index] set unless poisoned; then IDLE.
  - FillValid outside BURST is ignored.
- Misses while Busy:
  - Reported as Match=0.
  - Do not queue a fill; requester retries.
  - Hits to other lines are served normally during a fill.
- Snoop writes (any WE bit set):
  - Line valid and tag equal → enabled bytes are written into that word in the same cycle (write-through update). A RDReq to that word next cycle returns the updated bytes.
  - Line is the one being filled (REQ/BURST, same index and tag) → set poison. The line completes but valid stays 0.
  - Snoop write and FillValid to the same word in the same cycle → snoop bytes win; poison still set.
- Flush:
  - Clears all valid bits next edge.
  - A fill in progress continues, but is poisoned.
  - Flush concurrent with a read: that read reports Match per pre-flush state. The next cycle misses.
- Simultaneous read hit and fill write to a different line: both proceed; no stall.
- Reset mid-burst: FSM to IDLE immediately; FillReq drops asynchronously. The bus side must tolerate the abandoned burst.

Test Plan:
- Reset, then RDReq RDA=0x0000_1000 → next cycle RDValid=1, Match=0; FillReq=1, FillA=0x0000_1000. FillAck, then 4 FillValid words 0xA0..0xA3 → Busy=0. RDReq 0x1008 → Match=1, RDD=0xA2.
- After the fill above, snoop WRA=0x1004, WRD=0x1234_5678, WE=4'b0011 over word 0xA1 → RDReq 0x1004 returns RDD=0x0000_5678. Snoop to 0x2004 (same index, other tag) → no change.
- During BURST for 0x3000, snoop write to 0x300C → fill completes, Busy=0. RDReq 0x3000 → Match=0 and a new fill starts.
- With 0x1000 valid and a fill of 0x4010 in progress: RDReq 0x1004 → Match=1. RDReq 0x5000 → Match=0, no second FillReq until Busy=0.
- Flush asserted with lines 0x1000 and 0x1010 valid → both miss afterwards. Flush during BURST → that line stays invalid.
- nRST low mid-BURST after 2 words → FillReq=0, Busy=0, RDValid=0 immediately. After release, RDReq to the interrupted line → Match=0.
